// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point multiplier result path.
package fp_pkg;

  // Default word format: {sign, exponent[FP_M], mantissa[FP_N-FP_M-1]}
  localparam int FP_N = 32;
  localparam int FP_M = 8;

  // IEEE-style exponent bias for the default exponent width
  localparam int EXP_BIAS = (2 ** (FP_M - 1)) - 1;

  // Width of the saturating exception event counters
  localparam int CNT_W = 8;

  // One buffered multiplier result with its exception flags
  typedef struct packed {
    logic [FP_N-1:0] data;
    logic            ovf;
    logic            unf;
  } fp_entry_t;

  // Exponent bias for an arbitrary exponent field width
  function automatic int exp_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with a registered head word: the entry at the read pointer
// is always presented from a flop, so the consumer sees a stable word while it
// stalls, and a word written into an empty FIFO appears one cycle later.
module fp_sync_fifo
  import fp_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       ready,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] cnt;
  logic [LVL_W-1:0] cnt_nxt;
  logic [W-1:0]     head_q;
  logic [W-1:0]     head_nxt;
  logic             run_q;
  logic             push;
  logic             pop;

  // Ready depends only on flops, so there is no path from the consumer's
  // rd_en back to the producer; a full FIFO refuses even when popping.
  assign ready   = run_q && (cnt < LVL_W'(DEPTH));
  assign valid   = (cnt != '0);
  assign push    = wr_en && ready;
  assign pop     = rd_en && valid;
  assign rd_data = head_q;
  assign count   = cnt;

  // Next pointers, occupancy and head word. Pointers wrap naturally because
  // DEPTH is a power of two. The head comes from the write port when the
  // incoming word lands exactly at the next read location (empty FIFO, or
  // the last stored word being popped), otherwise from storage.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    head_nxt   = '0;
    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_nxt = cnt + LVL_W'(1);
    end else if (!push && pop) begin
      cnt_nxt = cnt - LVL_W'(1);
    end
    if (cnt_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        head_nxt = wr_data;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Control state and the visible head register
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      run_q  <= 1'b1;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      head_q <= head_nxt;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/fp_result_buffer.sv
// Elastic buffer for floating-point multiplier results. Words and their
// overflow/underflow flags are queued in fp_sync_fifo; this level resolves
// conflicting flags on entry and keeps sticky flags and saturating event
// counters for the accepted results.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int n     = 32,
  parameter int m     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [n-1:0]               in_data,
  input  logic                       in_ovf,
  input  logic                       in_unf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [n-1:0]               out_data,
  output logic                       out_ovf,
  output logic                       out_unf,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sticky_ovf,
  output logic                       sticky_unf,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [CNT_W-1:0]           unf_cnt,
  input  logic                       clr_sticky
);

  localparam int ENTRY_W = n + 2;

  // The word must hold a sign bit, a non-empty exponent and a mantissa
  if ((m < 1) || (m > n - 2)) begin : g_bad_format
    $error("fp_result_buffer: exponent width m does not fit word width n");
  end

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               push;
  logic               ovf_evt;
  logic               unf_evt;
  logic               ovf_store;
  logic               unf_store;

  // Counter increment that holds at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Overflow dominates: a result flagged both ways is stored and counted as
  // an overflow only.
  assign ovf_store = in_ovf;
  assign unf_store = in_unf && !in_ovf;
  assign wr_entry  = {in_data, ovf_store, unf_store};

  assign push    = in_valid && in_ready;
  assign ovf_evt = push && ovf_store;
  assign unf_evt = push && unf_store;

  fp_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (wr_entry),
    .rd_en   (out_ready),
    .rd_data (rd_entry),
    .ready   (in_ready),
    .valid   (out_valid),
    .count   (level)
  );

  assign out_data = rd_entry[ENTRY_W-1:2];
  assign out_ovf  = rd_entry[1];
  assign out_unf  = rd_entry[0];

  // Overflow statistics; a flagged push in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      ovf_cnt    <= '0;
    end else if (clr_sticky) begin
      sticky_ovf <= ovf_evt;
      ovf_cnt    <= ovf_evt ? CNT_W'(1) : '0;
    end else if (ovf_evt) begin
      sticky_ovf <= 1'b1;
      ovf_cnt    <= sat_inc(ovf_cnt);
    end
  end

  // Underflow statistics, same clear/push priority as overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_unf <= 1'b0;
      unf_cnt    <= '0;
    end else if (clr_sticky) begin
      sticky_unf <= unf_evt;
      unf_cnt    <= unf_evt ? CNT_W'(1) : '0;
    end else if (unf_evt) begin
      sticky_unf <= 1'b1;
      unf_cnt    <= sat_inc(unf_cnt);
    end
  end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed bench for fp_result_buffer with a queue scoreboard and a
// reference model of occupancy and exception statistics.
module tb_fp_result_buffer;

  localparam int N     = 32;
  localparam int M     = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [N-1:0] in_data;
  logic        in_ovf;
  logic        in_unf;
  logic        out_valid;
  logic        out_ready;
  logic [N-1:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic [2:0]  level;
  logic        sticky_ovf;
  logic        sticky_unf;
  logic [7:0]  ovf_cnt;
  logic [7:0]  unf_cnt;
  logic        clr_sticky;

  typedef struct packed {
    logic [N-1:0] d;
    logic         o;
    logic         u;
  } ent_t;

  ent_t sb[$];
  logic e_sovf;
  logic e_sunf;
  int   e_covf;
  int   e_cunf;
  int   checks;
  int   errors;

  fp_result_buffer #(.n(N), .m(M), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ovf     (in_ovf),
    .in_unf     (in_unf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .level      (level),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare everything the model predicts after a clock edge
  task automatic post_checks();
    check("level", 64'(level), 64'(sb.size()));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_data", 64'(out_data), 64'(sb[0].d));
      check("head_ovf", 64'(out_ovf), 64'(sb[0].o));
      check("head_unf", 64'(out_unf), 64'(sb[0].u));
    end
    check("sticky_ovf", 64'(sticky_ovf), 64'(e_sovf));
    check("sticky_unf", 64'(sticky_unf), 64'(e_sunf));
    check("ovf_cnt", 64'(ovf_cnt), 64'(e_covf));
    check("unf_cnt", 64'(unf_cnt), 64'(e_cunf));
  endtask

  // Drive one cycle of stimulus, update the scoreboard, advance the clock
  task automatic step(input logic v, input logic [N-1:0] d, input logic o,
                      input logic u, input logic rdy, input logic clr);
    ent_t e;
    logic p;
    logic q;
    logic po;
    logic pu;
    in_valid   = v;
    in_data    = d;
    in_ovf     = o;
    in_unf     = u;
    out_ready  = rdy;
    clr_sticky = clr;
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    p = v && (sb.size() < DEPTH);
    q = rdy && (sb.size() != 0);
    if (q) begin
      e = sb.pop_front();
      check("pop_data", 64'(out_data), 64'(e.d));
      check("pop_ovf", 64'(out_ovf), 64'(e.o));
      check("pop_unf", 64'(out_unf), 64'(e.u));
    end
    if (p) begin
      e.d = d;
      e.o = o;
      e.u = u && !o;
      sb.push_back(e);
    end
    po = p && o;
    pu = p && u && !o;
    if (clr) begin
      e_sovf = po;
      e_covf = po ? 1 : 0;
      e_sunf = pu;
      e_cunf = pu ? 1 : 0;
    end else begin
      if (po) begin
        e_sovf = 1'b1;
        e_covf = (e_covf == 255) ? 255 : e_covf + 1;
      end
      if (pu) begin
        e_sunf = 1'b1;
        e_cunf = (e_cunf == 255) ? 255 : e_cunf + 1;
      end
    end
    @(posedge clk);
    #1;
    post_checks();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_ovf     = 1'b0;
    in_unf     = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    e_sovf = 1'b0;
    e_sunf = 1'b0;
    e_covf = 0;
    e_cunf = 0;
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'({out_ovf, out_unf}), 64'd0);
    check("rst_sticky", 64'({sticky_ovf, sticky_unf}), 64'd0);
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    check("rst_unf_cnt", 64'(unf_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_level", 64'(level), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // Single push into an empty buffer shows up the next cycle
    step(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'h4040_0000);
    check("lat_level", 64'(level), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill past capacity with the consumer stalled, then drain in order
    for (int i = 1; i <= 5; i++) step(1'b1, N'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_level", 64'(level), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drained_level", 64'(level), 64'd0);

    // Full buffer with a pop must not take a push in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + N'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop_level", 64'(level), 64'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Steady push and pop at level 2
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i <= 5; i++) begin
      step(1'b1, 32'hB0 + N'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      check("flow_level", 64'(level), 64'd2);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Both flags set: stored and counted as overflow only
    step(1'b1, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_out_ovf", 64'(out_ovf), 64'd1);
    check("both_out_unf", 64'(out_unf), 64'd0);
    check("both_unf_cnt", 64'(unf_cnt), 64'd0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("unf_cnt_one", 64'(unf_cnt), 64'd1);

    // Saturation of the overflow counter
    for (int i = 0; i < 300; i++) step(1'b1, N'(i), 1'b1, 1'b0, 1'b1, 1'b0);
    check("sat_sticky", 64'(sticky_ovf), 64'd1);
    check("sat_ovf_cnt", 64'(ovf_cnt), 64'd255);
    step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_push_cnt", 64'(ovf_cnt), 64'd1);
    check("clr_push_sticky", 64'(sticky_ovf), 64'd1);
    check("clr_keeps_fifo", 64'(level), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_cnt", 64'(ovf_cnt), 64'd0);
    check("clr_fifo_data", 64'(out_data), 64'hC0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation discards entries and statistics
    for (int i = 0; i < 3; i++) step(1'b1, 32'hD0 + N'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_level", 64'(level), 64'd3);
    do_reset();
    step(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_result_buffer.md
FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning total floating-point word width.
REQ-002 The block SHALL have parameter m, default 8, meaning exponent field width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  multiplier result present this cycle.
REQ-007 Port in_ready  output  1  buffer can accept this cycle.
REQ-008 Port in_data  input  n  multiplier result word {sign, exponent[m], mantissa[n-m-1]}.
REQ-009 Port in_ovf  input  1  multiplier overflow flag for in_data.
REQ-010 Port in_unf  input  1  multiplier underflow flag for in_data.
REQ-011 Port out_valid  output  1  head entry available.
REQ-012 Port out_ready  input  1  consumer takes head entry.
REQ-013 Port out_data  output  n  head entry word.
REQ-014 Port out_ovf, out_unf  output  1 each  head entry flags.
REQ-015 Port level  output  clog2(DEPTH)+1  current occupancy.
REQ-016 Port sticky_ovf, sticky_unf  output  1 each  accumulated exception flags.
REQ-017 Port ovf_cnt, unf_cnt  output  8 each  saturating exception event counters.
REQ-018 Port clr_sticky  input  1  clears sticky flags and counters.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (level < DEPTH), derived only from registered state, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (level != 0); out_data/out_ovf/out_unf SHALL be the head entry, registered-read, stable while out_valid && !out_ready.
REQ-022 Latency: an entry pushed into an empty buffer SHALL appear on out_valid the following cycle; no same-cycle bypass.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-024 When full, in_ready=0, and a simultaneous pop SHALL NOT admit a push that cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-026 If in_ovf and in_unf are both 1 on push, the stored entry SHALL have ovf=1, unf=0, and only the overflow statistics SHALL update.
REQ-027 Each push with stored ovf=1 SHALL set sticky_ovf and increment ovf_cnt, saturating at 255; likewise unf for sticky_unf/unf_cnt.
REQ-028 clr_sticky SHALL clear sticky flags and counters the next cycle; a flagged push in the same cycle SHALL win, giving flag=1 and counter=1.
REQ-029 FIFO data and status SHALL be unaffected by clr_sticky.

Reset
REQ-030 With rst=1 at a clock edge: level=0, pointers=0, out_valid=0, in_ready=0 during reset, sticky_ovf=sticky_unf=0, ovf_cnt=unf_cnt=0, out_data/out_ovf/out_unf=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; in_ready SHALL return to 1 the first cycle after rst deasserts.

Structure
REQ-032 Shared package fp_pkg SHALL hold the result-entry struct {data[n], ovf, unf}, the exponent-bias constant 2**(m-1)-1, and the counter-width constant 8.
REQ-033 Storage and pointers SHALL be one sub-module, fp_sync_fifo; flag statistics SHALL stay in fp_result_buffer.

Verification
REQ-034 Reset, then push 0x40400000 (ovf=0, unf=0) -> next cycle out_valid=1, out_data=0x40400000, level=1.
REQ-035 DEPTH=4, out_ready=0, push 5 words 0x1..0x5 -> level=4, in_ready=0, fifth not accepted; drain yields 0x1..0x4 in order.
REQ-036 level=2 with push and pop in the same cycle for 3 cycles -> level stays 2 and output order matches input order.
REQ-037 300 pushes with in_ovf=1 -> sticky_ovf=1, ovf_cnt=255; clr_sticky with a simultaneous flagged push -> ovf_cnt=1, sticky_ovf=1.
REQ-038 Push with in_ovf=1, in_unf=1 -> out_ovf=1, out_unf=0, unf_cnt unchanged.
REQ-039 rst asserted with level=3 -> next cycle level=0, out_valid=0, sticky flags and counters 0.
